// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the integer register file.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   AW_DEF              : index width for the default register count
//   reg_idx_t / xword_t : register index and data word types (default sizes)
//   ZERO_REG            : index of the hardwired-zero register
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32'd32;
    localparam int unsigned NREG_DEF = 32'd32;
    localparam int unsigned AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

    localparam int unsigned ZERO_REG = 32'd0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for the in-order pipeline.
//   clk, rst_n  : clock and synchronous active-low reset
//   ra          : NRP packed read indices; ra_busy[p] = busy bit for port p
//   iss_valid/iss_rd/iss_ready : issue handshake, sets busy[iss_rd]
//   wen/wa      : writeback, clears busy[wa]
//   flush       : clears every busy bit; a same-cycle issue does not set
//   err         : sticky flag, writeback to a register that was not busy
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NRP  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRP*AW-1:0] ra,
    output logic [NRP-1:0]    ra_busy,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_ready,
    input  logic              wen,
    input  logic [AW-1:0]     wa,
    input  logic              flush,
    output logic              err
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic            err_r;
    logic            err_set_s;
    logic            wb_valid_s;

    assign wb_valid_s = wen && (wa != ZERO_IDX);
    assign err        = err_r;

    // Issue handshake: a busy destination stalls unless this cycle's writeback retires it.
    // busy_r[0] is never set, so iss_rd = 0 always reports ready.
    always_comb begin
        iss_ready = 1'b1;
        if (busy_r[iss_rd] && !(wen && (wa == iss_rd))) begin
            iss_ready = 1'b0;
        end else begin
            iss_ready = 1'b1;
        end
    end

    // Busy bit seen by each read port (bypass masking happens in the top).
    always_comb begin
        ra_busy = '0;
        for (int p = 0; p < NRP; p++) begin
            ra_busy[p] = busy_r[ra[p*AW +: AW]];
        end
    end

    // Next busy vector: flush wins outright, otherwise issue-set overrides writeback-clear.
    always_comb begin
        busy_nxt_s = busy_r;
        err_set_s  = wb_valid_s && !busy_r[wa] && !flush;
        if (flush) begin
            busy_nxt_s = '0;
        end else begin
            if (wb_valid_s) begin
                busy_nxt_s[wa] = 1'b0;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
            if (iss_valid && iss_ready && (iss_rd != ZERO_IDX)) begin
                busy_nxt_s[iss_rd] = 1'b1;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
    end

    // Busy and sticky error state; reset discards any pending busy bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= '0;
            err_r  <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            err_r  <= err_r | err_set_s;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with busy scoreboard.
//   clk, rst_n : clock and synchronous active-low reset (clears data, busy, err)
//   ra / rd    : NRP combinational read ports, packed p*AW / p*XLEN
//   rd_busy    : per-port pending-write indication (0 for index 0)
//   iss_valid, iss_rd, iss_ready : issue handshake marking iss_rd busy
//   wen, wa, wd: writeback; clears busy[wa], writes data (index 0 ignored)
//   flush      : clears all busy bits, data kept
//   err        : sticky, writeback to a non-busy register
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data to matching read ports (write-through); otherwise reads see the old value.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP  = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NRP*$clog2(NREG)-1:0]         ra,
    output logic [NRP*XLEN-1:0]                 rd,
    output logic [NRP-1:0]                      rd_busy,
    input  logic                                iss_valid,
    input  logic [$clog2(NREG)-1:0]             iss_rd,
    output logic                                iss_ready,
    input  logic                                wen,
    input  logic [$clog2(NREG)-1:0]             wa,
    input  logic [XLEN-1:0]                     wd,
    input  logic                                flush,
    output logic                                err
);

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [XLEN-1:0] regs_r [NREG];
    logic [NRP-1:0]  sb_busy_s;

    regfile_scoreboard #(
        .NREG (NREG),
        .NRP  (NRP),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra        (ra),
        .ra_busy   (sb_busy_s),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .wen       (wen),
        .wa        (wa),
        .flush     (flush),
        .err       (err)
    );

    // Data array: synchronous reset clears everything, index 0 is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wen && (wa != ZERO_IDX)) begin
            regs_r[wa] <= wd;
        end
    end

    // Combinational read muxes with hardwired-zero index and optional write-through.
    always_comb begin
        logic [AW-1:0] idx_s;
        rd      = '0;
        rd_busy = '0;
        idx_s   = '0;
        for (int p = 0; p < NRP; p++) begin
            idx_s = ra[p*AW +: AW];
            if (idx_s == ZERO_IDX) begin
                rd[p*XLEN +: XLEN] = '0;
                rd_busy[p]         = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (wen && (wa != ZERO_IDX) && (wa == idx_s)) begin
                rd[p*XLEN +: XLEN] = wd;
                rd_busy[p]         = 1'b0;
            end
`endif
            else begin
                rd[p*XLEN +: XLEN] = regs_r[idx_s];
                rd_busy[p]         = sb_busy_s[p];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against a
// behavioural model (arrays of register values and busy flags).
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NRP*AW-1:0]    ra;
    logic [NRP*XLEN-1:0]  rd;
    logic [NRP-1:0]       rd_busy;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic                 iss_ready;
    logic                 wen;
    logic [AW-1:0]        wa;
    logic [XLEN-1:0]      wd;
    logic                 flush;
    logic                 err;

    int compared   = 0;
    int mismatched = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];
    bit              m_err;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra        (ra),
        .rd        (rd),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .wen       (wen),
        .wa        (wa),
        .wd        (wd),
        .flush     (flush),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit byp_hit(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        return wen && (wa != 0) && (wa == a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        return !(m_busy[iss_rd] && !(wen && (wa == iss_rd)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] ed;
        bit              eb;
        for (int p = 0; p < NRP; p++) begin
            a = ra[p*AW +: AW];
            if (a == 0) begin ed = '0; eb = 1'b0; end
            else if (byp_hit(a)) begin ed = wd; eb = 1'b0; end
            else begin ed = m_regs[a]; eb = m_busy[a]; end
            chk($sformatf("%s.rd%0d", tag, p), 64'(rd[p*XLEN +: XLEN]), 64'(ed));
            chk($sformatf("%s.busy%0d", tag, p), 64'(rd_busy[p]), 64'(eb));
        end
        chk({tag, ".ready"}, 64'(iss_ready), 64'(model_ready()));
        chk({tag, ".err"}, 64'(err), 64'(m_err));
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit rdy;
        if (!rst_n) begin
            model_reset();
        end else begin
            rdy = model_ready();
            if (wen && wa != 0 && !m_busy[wa] && !flush) m_err = 1'b1;
            if (wen && wa != 0) m_regs[wa] = wd;
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else begin
                if (wen) m_busy[wa] = 1'b0;
                if (iss_valid && rdy && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            end
        end
    endtask

    // Called 1 time unit after a rising edge: check at +4, then clock, then +1.
    task automatic step(input string tag);
        #3;
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; ra = '0; iss_valid = 1'b0; iss_rd = '0;
        wen = 1'b0; wa = '0; wd = '0; flush = 1'b0;
    endtask

    function automatic logic [NRP*AW-1:0] mk_ra(input int a1, input int a0);
        return {AW'(a1), AW'(a0)};
    endfunction

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;

        // Reset state read-back
        ra = mk_ra(0, 5);
        #1;
        chk("rst.rd", 64'(rd), 64'd0);
        chk("rst.busy", 64'(rd_busy), 64'd0);
        chk("rst.ready", 64'(iss_ready), 64'd1);
        chk("rst.err", 64'(err), 64'd0);
        step("rst");

        // Issue x7, stall on re-issue, writeback clears
        idle(); iss_valid = 1'b1; iss_rd = 5'd7;
        step("iss7");
        ra = mk_ra(0, 7);
        #1;
        chk("iss7.busy", 64'(rd_busy[0]), 64'd1);
        chk("iss7.stall", 64'(iss_ready), 64'd0);
        step("reiss7");
        idle(); wen = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF; ra = mk_ra(0, 7);
        step("wb7");
        idle(); ra = mk_ra(0, 7);
        #1;
        chk("wb7.rd", 64'(rd[XLEN-1:0]), 64'hDEADBEEF);
        chk("wb7.busy", 64'(rd_busy[0]), 64'd0);
        step("post7");

        // Same-cycle writeback and issue to busy x9
        idle(); iss_valid = 1'b1; iss_rd = 5'd9;
        step("iss9");
        idle(); iss_valid = 1'b1; iss_rd = 5'd9; wen = 1'b1; wa = 5'd9; wd = 32'h0BADF00D;
        #1;
        chk("x9.ready", 64'(iss_ready), 64'd1);
        step("x9");
        idle(); ra = mk_ra(9, 9);
        #1;
        chk("x9.busy", 64'(rd_busy), 64'd3);
        chk("x9.rd", 64'(rd[XLEN-1:0]), 64'h0BADF00D);
        step("x9post");

        // x0 handling
        idle(); wen = 1'b1; wa = 5'd0; wd = 32'h1234; iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        chk("x0.ready", 64'(iss_ready), 64'd1);
        step("x0");
        idle(); ra = mk_ra(0, 0);
        #1;
        chk("x0.rd", 64'(rd), 64'd0);
        chk("x0.busy", 64'(rd_busy), 64'd0);
        chk("x0.err", 64'(err), 64'd0);
        step("x0post");

        // Flush then writeback to a no-longer-busy register
        idle(); iss_valid = 1'b1; iss_rd = 5'd3;
        step("iss3");
        idle(); iss_valid = 1'b1; iss_rd = 5'd4;
        step("iss4");
        idle(); flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd5;
        step("flush");
        idle(); ra = mk_ra(4, 3);
        #1;
        chk("flush.busy", 64'(rd_busy), 64'd0);
        step("postflush");
        idle(); wen = 1'b1; wa = 5'd3; wd = 32'h33;
        step("wb3");
        idle();
        #1;
        chk("err.set", 64'(err), 64'd1);
        step("err1");
        step("err2");
        rst_n = 1'b0;
        step("rst2");
        idle();
        #1;
        chk("err.clr", 64'(err), 64'd0);
        step("postrst");

        // Write-through vs old-value read
        idle(); wen = 1'b1; wa = 5'd12; wd = 32'hA5A5A5A5; ra = mk_ra(12, 0);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp.same", 64'(rd[2*XLEN-1:XLEN]), 64'hA5A5A5A5);
`else
        chk("byp.same", 64'(rd[2*XLEN-1:XLEN]), 64'd0);
`endif
        step("byp");
        idle(); ra = mk_ra(12, 0);
        #1;
        chk("byp.next", 64'(rd[2*XLEN-1:XLEN]), 64'hA5A5A5A5);
        step("bypnext");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            iss_valid = $urandom_range(0, 1);
            iss_rd    = AW'($urandom_range(0, 7));
            wen       = $urandom_range(0, 1);
            wa        = AW'($urandom_range(0, 7));
            wd        = $urandom;
            ra        = mk_ra($urandom_range(0, 31), $urandom_range(0, 7));
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
